// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, ALUOp codes, sequencer states and ID/EX control bundle
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RFN  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  typedef enum logic [1:0] {IDLE, MUL, WB} mulState_t;
  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memtoReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [2:0] aluOp;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: Booth multiply sequencer (IDLE -> MUL -> WB) driving start, HI/LO write, abort and front-end stall
//   accept     : MULT accepted in ID this cycle
//   flush      : branch kill; aborts a running multiply
//   mul_start  : registered one-cycle start pulse
//   hilo_write : HI/LO write enable in WB, masked by a same-cycle flush
//   mul_abort  : registered one-cycle pulse when a running multiply is killed
//   pipe_stall : high whenever the sequencer is busy
module mul_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RADIX4 = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic flush,
  output logic mul_start,
  output logic hilo_write,
  output logic mul_abort,
  output logic pipe_stall
);
  localparam int MUL_CYCLES = (RADIX4 != 0) ? DATA_W / 2 : DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  mulState_t state, stateNext;
  logic [CW-1:0] count, countNext;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mul_start <= 1'b0;
      mul_abort <= 1'b0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      mul_start <= accept && state == IDLE;
      mul_abort <= flush && state != IDLE;
    end
  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      IDLE: if (accept) begin
        stateNext = MUL;
        countNext = CW'(MUL_CYCLES - 1);
      end
      MUL: if (flush) begin
        stateNext = IDLE;
        countNext = '0;
      end else if (count == '0) stateNext = WB;
      else countNext = count - CW'(1);
      default: stateNext = IDLE;
    endcase
  end
  assign pipe_stall = state != IDLE;
  // a flush landing in WB kills the write in that same cycle
  assign hilo_write = state == WB && !flush;
endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: registered MIPS ID/EX decoder with bubble insertion and MULT sequencing
//   instr_valid/opcode/funct : instruction in ID
//   stall_in                 : load-use hazard bubble request
//   flush                    : branch taken in EX, kills ID
//   RegDst..Branch, ALUOp    : registered ID/EX controls
//   mul_start/hilo_write/mul_abort/pipe_stall : multiplier sequencing
//   illegal_op               : registered pulse for an undefined, non-bubbled opcode
module pipe_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RADIX4 = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       stall_in,
  input  logic       flush,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic [2:0] ALUOp,
  output logic       mul_start,
  output logic       hilo_write,
  output logic       mul_abort,
  output logic       pipe_stall,
  output logic       illegal_op
);
  ctrl_t dec, ctrlQ;
  logic decIllegal, bubble, accept;
  always_comb begin
    dec = CTRL_NOP;
    decIllegal = 1'b0;
    case (opcode)
      OP_RTYPE: if (funct != FN_MULT) begin
        dec.regDst = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluOp = ALU_RFN;
      end
      OP_LW: begin
        dec.aluSrc = 1'b1;
        dec.memtoReg = 1'b1;
        dec.regWrite = 1'b1;
        dec.memRead = 1'b1;
        dec.aluOp = ALU_ADD;
      end
      OP_SW: begin
        dec.aluSrc = 1'b1;
        dec.memWrite = 1'b1;
        dec.aluOp = ALU_ADD;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluOp = ALU_SUB;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        dec.aluSrc = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluOp = opcode == OP_ADDI ? ALU_ADD : opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_SLT;
      end
      default: decIllegal = 1'b1;
    endcase
  end
  // any bubble source zeroes the bundle, so priority only matters inside the sequencer
  assign bubble = !instr_valid || flush || stall_in || pipe_stall;
  assign accept = !bubble && opcode == OP_RTYPE && funct == FN_MULT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrlQ      <= CTRL_NOP;
      illegal_op <= 1'b0;
    end else begin
      ctrlQ      <= bubble ? CTRL_NOP : dec;
      illegal_op <= !bubble && decIllegal;
    end
  assign {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp} = ctrlQ;
  mul_sequencer #(.DATA_W(DATA_W), .RADIX4(RADIX4)) u_seq (
    .clk(clk),
    .rst_n(rst_n),
    .accept(accept),
    .flush(flush),
    .mul_start(mul_start),
    .hilo_write(hilo_write),
    .mul_abort(mul_abort),
    .pipe_stall(pipe_stall)
  );
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: table-driven and randomized check of radix-2 and radix-4 control units against a cycle-count model
module tb_pipe_control_unit;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, stall_in = 1'b0, flush = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [1:0] regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch;
  logic [1:0] mulStart, hiloWrite, mulAbort, pipeStall, illegalOp;
  logic [2:0] aluOp [2];
  always #5 clk = ~clk;
  for (genvar d = 0; d < 2; d++) begin : g_dut
    pipe_control_unit #(.DATA_W(32), .RADIX4(d)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
      .stall_in(stall_in), .flush(flush),
      .RegDst(regDst[d]), .ALUSrc(aluSrc[d]), .MemtoReg(memtoReg[d]), .RegWrite(regWrite[d]),
      .MemRead(memRead[d]), .MemWrite(memWrite[d]), .Branch(branch[d]), .ALUOp(aluOp[d]),
      .mul_start(mulStart[d]), .hilo_write(hiloWrite[d]), .mul_abort(mulAbort[d]),
      .pipe_stall(pipeStall[d]), .illegal_op(illegalOp[d])
    );
  end
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [9:0] ctl;
    logic       ill;
  } vec_t;
  vec_t vecs[10];
  int checks = 0, errors = 0;
  int left[2];
  int mc[2] = '{32, 16};
  int stallCnt[2], hiloCnt[2], startCnt[2], abortCnt[2];
  localparam logic [5:0] MULT_FN = 6'b011000;
  localparam logic [9:0] R_CTL = 10'b1001000_010;
  function automatic logic [14:0] got(input int d);
    return {regDst[d], aluSrc[d], memtoReg[d], regWrite[d], memRead[d], memWrite[d], branch[d],
            aluOp[d], illegalOp[d], mulStart[d], mulAbort[d], pipeStall[d], hiloWrite[d]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic decodeRef(input logic [5:0] op, input logic [5:0] fn, output logic [9:0] ctl, output logic ill);
    ctl = '0;
    ill = 1'b1;
    if (op == 6'b000000) begin
      ctl = (fn == MULT_FN) ? 10'b0 : R_CTL;
      ill = 1'b0;
    end else
      for (int i = 0; i < 10; i++)
        if (vecs[i].op == op) begin
          ctl = vecs[i].ctl;
          ill = vecs[i].ill;
        end
  endtask
  task automatic clearCounts();
    for (int d = 0; d < 2; d++) begin
      stallCnt[d] = 0;
      hiloCnt[d] = 0;
      startCnt[d] = 0;
      abortCnt[d] = 0;
    end
  endtask
  task automatic apply(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic st, input logic fl, input string tag);
    logic [9:0] ctl;
    logic ill, busy, bub, acc;
    logic [14:0] exp;
    instr_valid = v;
    opcode = op;
    funct = fn;
    stall_in = st;
    flush = fl;
    @(posedge clk);
    decodeRef(op, fn, ctl, ill);
    #1;
    for (int d = 0; d < 2; d++) begin
      busy = left[d] > 0;
      bub = !v || fl || st || busy;
      acc = !bub && op == 6'b000000 && fn == MULT_FN;
      left[d] = acc ? mc[d] + 1 : (busy && fl) ? 0 : busy ? left[d] - 1 : 0;
      exp = {bub ? 10'b0 : ctl, !bub && ill, acc, busy && fl, left[d] > 0, left[d] == 1 && !fl};
      check($sformatf("%s dut%0d op=%b fn=%b", tag, d, op, fn), 32'(got(d)), 32'(exp));
      stallCnt[d] += int'(pipeStall[d]);
      hiloCnt[d] += int'(hiloWrite[d]);
      startCnt[d] += int'(mulStart[d]);
      abortCnt[d] += int'(mulAbort[d]);
    end
  endtask
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) apply(1'b1, 6'b100011, 6'b0, 1'b0, 1'b0, tag);
  endtask
  task automatic asyncReset(input string tag);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d", tag, d), 32'(got(d)), 32'd0);
      left[d] = 0;
    end
    #2 rst_n = 1'b1;
  endtask
  task automatic multCounts(input string tag, input int start, input int abort, input int hilo, input int s0, input int s1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s start dut%0d", tag, d), startCnt[d], start);
      check($sformatf("%s abort dut%0d", tag, d), abortCnt[d], abort);
      check($sformatf("%s hilo dut%0d", tag, d), hiloCnt[d], hilo);
      check($sformatf("%s stall dut%0d", tag, d), stallCnt[d], d == 0 ? s0 : s1);
    end
  endtask
  initial begin
    vecs[0] = '{6'b000000, 6'b100000, R_CTL, 1'b0};
    vecs[1] = '{6'b100011, 6'b000000, 10'b0111100_000, 1'b0};
    vecs[2] = '{6'b101011, 6'b000000, 10'b0100010_000, 1'b0};
    vecs[3] = '{6'b000100, 6'b000000, 10'b0000001_001, 1'b0};
    vecs[4] = '{6'b001000, 6'b000000, 10'b0101000_000, 1'b0};
    vecs[5] = '{6'b001100, 6'b000000, 10'b0101000_011, 1'b0};
    vecs[6] = '{6'b001101, 6'b000000, 10'b0101000_100, 1'b0};
    vecs[7] = '{6'b001010, 6'b000000, 10'b0101000_101, 1'b0};
    vecs[8] = '{6'b111111, 6'b000000, 10'b0, 1'b1};
    vecs[9] = '{6'b000000, MULT_FN, 10'b0, 1'b0};
    left = '{0, 0};
    instr_valid = 1'b1;
    opcode = 6'b100011;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("reset dut%0d", d), 32'(got(d)), 32'd0);
    #2 rst_n = 1'b1;
    apply(1'b1, 6'b100011, 6'b0, 1'b0, 1'b0, "first lw");
    for (int d = 0; d < 2; d++) check($sformatf("first lw ctl dut%0d", d), 32'(got(d) >> 5), 32'(10'b0111100_000));
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, vecs[i].op, vecs[i].fn, 1'b0, 1'b0, "sweep");
      for (int d = 0; d < 2; d++)
        check($sformatf("sweep table %0d dut%0d", i, d), 32'(got(d) >> 4), 32'({vecs[i].ctl, vecs[i].ill}));
    end
    clearCounts();
    apply(1'b1, 6'b000000, MULT_FN, 1'b0, 1'b0, "mult");
    idle(40, "mult run");
    multCounts("mult", 1, 0, 1, 33, 17);
    clearCounts();
    apply(1'b1, 6'b000000, MULT_FN, 1'b0, 1'b0, "abort");
    idle(5, "abort run");
    apply(1'b1, 6'b100011, 6'b0, 1'b0, 1'b1, "abort flush");
    idle(3, "abort after");
    multCounts("abort", 1, 1, 0, 6, 6);
    clearCounts();
    apply(1'b1, 6'b000000, MULT_FN, 1'b0, 1'b1, "mult+flush");
    apply(1'b1, 6'b100011, 6'b0, 1'b1, 1'b0, "lw+stall");
    apply(1'b1, 6'b100011, 6'b0, 1'b0, 1'b0, "lw after stall");
    multCounts("mult+flush", 0, 0, 0, 0, 0);
    clearCounts();
    apply(1'b1, 6'b000000, MULT_FN, 1'b0, 1'b0, "midreset");
    idle(21, "midreset run");
    asyncReset("midreset");
    clearCounts();
    apply(1'b1, 6'b000000, MULT_FN, 1'b0, 1'b0, "post reset mult");
    idle(40, "post reset run");
    multCounts("post reset", 1, 0, 1, 33, 17);
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [5:0] op, fn;
      r = int'($urandom_range(0, 11));
      op = r < 10 ? vecs[r].op : r == 10 ? 6'($urandom) : 6'b000000;
      fn = r < 10 ? vecs[r].fn : r == 10 ? 6'($urandom) : MULT_FN;
      apply($urandom_range(0, 9) != 0, op, fn, $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Registered, parametrised control unit for the pipelined MIPS core. It decodes opcode/funct in ID into registered ID/EX control signals and inserts bubbles for hazard stalls and branch flushes. It also sequences the multi-cycle Booth multiplier for `MULT`, stalling the front end until HI/LO are written. It replaces the purely combinational decoder.

## Interface
**Parameters**
- `DATA_W`, default 32: multiplier operand width; must be even, at least 8.
- `RADIX4`, default 0: 0 selects radix-2 Booth, 1 selects radix-4.
- `MUL_CYCLES`, derived: `RADIX4 ? DATA_W/2 : DATA_W`.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `instr_valid` in 1: ID holds a real instruction.
- `opcode` in 6: instr[31:26].
- `funct` in 6: instr[5:0].
- `stall_in` in 1: load-use hazard from the hazard unit.
- `flush` in 1: branch taken in EX; kill ID.
- `RegDst`, `ALUSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch` out 1 each: registered ID/EX controls.
- `ALUOp` out 3: registered ALU operation.
- `mul_start` out 1: one-cycle start pulse to the Booth multiplier.
- `hilo_write` out 1: one-cycle HI/LO write enable.
- `mul_abort` out 1: one-cycle pulse when a multiply is killed.
- `pipe_stall` out 1: freezes PC and IF/ID.
- `illegal_op` out 1: registered pulse for an undefined opcode.

## Operation
**Decode map** (ALUOp encoding: 000 add, 001 sub, 010 R-funct, 011 and, 100 or, 101 slt; 110/111 reserved and never produced)
- R-type `000000`: RegDst=1, RegWrite=1, ALUOp=010.
- `100011` lw: ALUSrc, MemtoReg, RegWrite, MemRead; ALUOp=000.
- `101011` sw: ALUSrc, MemWrite; ALUOp=000.
- `000100` beq: Branch; ALUOp=001.
- `001000` addi: ALUSrc, RegWrite; ALUOp=000.
- `001100` andi: ALUSrc, RegWrite; ALUOp=011.
- `001101` ori: ALUSrc, RegWrite; ALUOp=100.
- `001010` slti: ALUSrc, RegWrite; ALUOp=101.
- R-type with funct `011000` (MULT): all ID/EX controls 0; starts the multiply sequence.
- Any other opcode: all controls 0 (NOP) and `illegal_op`=1 for one cycle.

**Bubbles.** ID/EX controls load all-zero when any of these hold: `!instr_valid`, `flush`, `stall_in`, `pipe_stall`.

**Priority.** `flush` > `pipe_stall` > `stall_in` > decode.

**Multiply FSM**
- IDLE → MUL on an accepted MULT (valid, no flush, no stall_in, not busy). `mul_start`=1 in the following cycle. Counter loads `MUL_CYCLES-1`.
- MUL: counter decrements each cycle; at 0, go to WB.
- WB: `hilo_write`=1, then go to IDLE.
- `pipe_stall` = (state != IDLE).
- `flush` while in MUL or WB: go to IDLE, pulse `mul_abort`, suppress `hilo_write`. A pending `mul_start` is still emitted, because flush is sampled after acceptance.
- Counter width is $clog2(DATA_W+1); it never wraps below 0.

## Timing
- Reset (asynchronous, `rst_n`=0): every output 0, state IDLE, counter 0. Reset mid-multiply abandons it silently; no `mul_abort`.
- Decode latency: 1 cycle (inputs at edge N, outputs valid after edge N).
- MULT accepted at edge N:
  - `mul_start` is high for cycle N..N+1.
  - `pipe_stall` is high from after edge N for `MUL_CYCLES+1` cycles.
  - `hilo_write` is high in the last of those cycles.
  - Stall releases after the following edge.
- `flush` and MULT in the same cycle: flush wins; no start, no stall.
- `stall_in` does not extend the multiply. While busy, `stall_in` is ignored: the bubble is already inserted.
- `illegal_op` is suppressed when the instruction is bubbled.

## Structure
- Package `mips_ctrl_pkg`:
  - opcode/funct localparams
  - ALUOp codes
  - state enum {IDLE, MUL, WB}
  - control-bundle struct.
- Sub-module `mul_sequencer`: owns the FSM, counter, `mul_start`, `hilo_write`, `mul_abort` and `pipe_stall`.
- Top level: decode logic and the ID/EX control register.

## Test plan
- **Reset then lw.** Drive `rst_n`=0 with opcode=`100011`: all outputs 0. Release reset and hold valid: after 1 edge, ALUSrc=MemtoReg=RegWrite=MemRead=1 and ALUOp=000.
- **Decode sweep.** Drive each table opcode in consecutive cycles and check each registered bundle. Opcode `111111` gives all zeros with `illegal_op`=1 for exactly 1 cycle.
- **MULT with DATA_W=32, RADIX4=0.** `mul_start` is 1 cycle; `pipe_stall` is high for 33 cycles; `hilo_write` is high in cycle 33 only. Repeat with RADIX4=1: stall is 17 cycles.
- **Abort.** Assert `flush` 5 cycles into MUL: `mul_abort` pulses, state returns to IDLE, `hilo_write` never asserts, and `pipe_stall` drops after that edge.
- **Simultaneous events.** MULT with `flush` in the same cycle: no `mul_start`, no stall. lw with `stall_in`: the controls are a bubble, and the next cycle decodes lw.
- **Reset mid-multiply.** Assert `rst_n`=0 at counter=10: all outputs go 0 immediately. After release, a new MULT completes normally.
